// File: rtl/code_loader.sv
// Boot-time program loader: receives a length-prefixed byte stream, packs big-endian 16-bit
// words into code memory from address 0, then asserts run. Optional checksum byte: CODE_LOADER_CHECKSUM_EN.
module code_loader #(
  parameter int MAX_WORDS = 512,
  parameter int ADDR_W    = 9
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              code_w_en,
  output logic [ADDR_W-1:0] code_addr_in,
  output logic [15:0]       code_in,
  output logic              run,
  output logic              busy,
  output logic              err
);

  typedef enum logic [3:0] {
    S_IDLE    = 4'd0,
    S_LEN_HI  = 4'd1,
    S_LEN_LO  = 4'd2,
    S_DATA_HI = 4'd3,
    S_DATA_LO = 4'd4,
    S_WRITE   = 4'd5,
`ifdef CODE_LOADER_CHECKSUM_EN
    S_CSUM    = 4'd6,
`endif
    S_DONE    = 4'd7,
    S_ERROR   = 4'd8
  } state_t;

  localparam logic [15:0] MaxLen = 16'(MAX_WORDS);

  state_t              state_q;
  logic [7:0]          len_hi_q;
  logic [15:0]         len_q;
  logic [7:0]          byte_hi_q;
  logic [ADDR_W:0]     cnt_q;
  logic [ADDR_W:0]     cnt_d;
  logic [ADDR_W-1:0]   addr_q;
  logic [ADDR_W-1:0]   code_addr_q;
  logic [15:0]         code_q;
  logic [15:0]         hdr_len;
`ifdef CODE_LOADER_CHECKSUM_EN
  logic [7:0]          csum_q;
`endif

  assign cnt_d   = cnt_q + (ADDR_W+1)'(1);
  assign hdr_len = {len_hi_q, in_data};

  // Every status output is a pure decode of the state register.
`ifdef CODE_LOADER_CHECKSUM_EN
  assign in_ready = (state_q inside {S_LEN_HI, S_LEN_LO, S_DATA_HI, S_DATA_LO, S_CSUM});
`else
  assign in_ready = (state_q inside {S_LEN_HI, S_LEN_LO, S_DATA_HI, S_DATA_LO});
`endif
  assign busy         = !(state_q inside {S_IDLE, S_DONE, S_ERROR});
  assign code_w_en    = (state_q == S_WRITE);
  assign run          = (state_q == S_DONE);
  assign err          = (state_q == S_ERROR);
  assign code_addr_in = code_addr_q;
  assign code_in      = code_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      len_hi_q    <= 8'd0;
      len_q       <= 16'd0;
      byte_hi_q   <= 8'd0;
      cnt_q       <= '0;
      addr_q      <= '0;
      code_addr_q <= '0;
      code_q      <= 16'd0;
`ifdef CODE_LOADER_CHECKSUM_EN
      csum_q      <= 8'd0;
`endif
    end else begin
      case (state_q)
        S_IDLE, S_DONE, S_ERROR: begin
          if (load) begin
            state_q <= S_LEN_HI;
            cnt_q   <= '0;
            addr_q  <= '0;
`ifdef CODE_LOADER_CHECKSUM_EN
            csum_q  <= 8'd0;
`endif
          end
        end
        S_LEN_HI: begin
          if (in_valid) begin
            len_hi_q <= in_data;
`ifdef CODE_LOADER_CHECKSUM_EN
            csum_q   <= csum_q ^ in_data;
`endif
            state_q  <= S_LEN_LO;
          end
        end
        S_LEN_LO: begin
          if (in_valid) begin
            len_q <= hdr_len;
`ifdef CODE_LOADER_CHECKSUM_EN
            csum_q <= csum_q ^ in_data;
`endif
            if ((hdr_len == 16'd0) || (hdr_len > MaxLen)) begin
              state_q <= S_ERROR;
            end else begin
              state_q <= S_DATA_HI;
            end
          end
        end
        S_DATA_HI: begin
          if (in_valid) begin
            byte_hi_q <= in_data;
`ifdef CODE_LOADER_CHECKSUM_EN
            csum_q    <= csum_q ^ in_data;
`endif
            state_q   <= S_DATA_LO;
          end
        end
        S_DATA_LO: begin
          // Word and address are captured together so they stay stable outside WRITE.
          if (in_valid) begin
            code_q      <= {byte_hi_q, in_data};
            code_addr_q <= addr_q;
`ifdef CODE_LOADER_CHECKSUM_EN
            csum_q      <= csum_q ^ in_data;
`endif
            state_q     <= S_WRITE;
          end
        end
        S_WRITE: begin
          cnt_q  <= cnt_d;
          addr_q <= addr_q + ADDR_W'(1);
          if (16'(cnt_d) == len_q) begin
`ifdef CODE_LOADER_CHECKSUM_EN
            state_q <= S_CSUM;
`else
            state_q <= S_DONE;
`endif
          end else begin
            state_q <= S_DATA_HI;
          end
        end
`ifdef CODE_LOADER_CHECKSUM_EN
        S_CSUM: begin
          if (in_valid) begin
            state_q <= (in_data == csum_q) ? S_DONE : S_ERROR;
          end
        end
`endif
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_code_loader.sv
// Self-checking bench for code_loader: a slot-list model of each load predicts every output cycle by cycle.
module tb_code_loader;
  localparam int MAXW = 512;
  localparam int AW   = 9;

  logic          clk = 1'b0;
  logic          rst, load, in_valid, in_ready, code_w_en, run, busy, err;
  logic [7:0]    in_data;
  logic [AW-1:0] code_addr_in;
  logic [15:0]   code_in;

  always #5 clk = ~clk;

  code_loader #(.MAX_WORDS(MAXW), .ADDR_W(AW)) dut (
    .clk(clk), .rst(rst), .load(load), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .code_w_en(code_w_en), .code_addr_in(code_addr_in),
    .code_in(code_in), .run(run), .busy(busy), .err(err)
  );

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;
  int exp_ready, exp_busy, exp_wen, exp_addr, exp_data, exp_run, exp_err;

  logic [7:0] stream[$];
  int it_kind[$];  // 0 = byte slot, 1 = write cycle
  int it_byte[$];
  int it_addr[$];
  int it_data[$];
  int exp_term;    // 0 = finishes with run, 1 = finishes with err

  int cyc_n = 0;
  int load_cyc = 0;
  int wr_cyc[$];
  int wr_addr[$];
  int wr_data[$];
  int run_cyc = -1;
  int err_cyc = -1;

  task automatic check(input string nm, input int act, input int ex);
    checks++;
    if (act != ex) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, ex, $time);
    end
  endtask

  always @(posedge clk) cyc_n <= cyc_n + 1;

  // Per-cycle comparison of every output against the model expectation.
  always @(negedge clk) begin
    if (chk_en) begin
      check("in_ready", int'(in_ready), exp_ready);
      check("busy", int'(busy), exp_busy);
      check("code_w_en", int'(code_w_en), exp_wen);
      check("code_addr_in", int'(code_addr_in), exp_addr);
      check("code_in", int'(code_in), exp_data);
      check("run", int'(run), exp_run);
      check("err", int'(err), exp_err);
    end
  end

  // Timing log relative to the cycle in which load was sampled.
  always @(negedge clk) begin
    if (code_w_en) begin
      wr_cyc.push_back(cyc_n - load_cyc);
      wr_addr.push_back(int'(code_addr_in));
      wr_data.push_back(int'(code_in));
    end
    if (cyc_n > load_cyc && run && run_cyc < 0) run_cyc = cyc_n - load_cyc;
    if (cyc_n > load_cyc && err && err_cyc < 0) err_cyc = cyc_n - load_cyc;
  end

  task automatic exp_zero();
    exp_ready = 0; exp_busy = 0; exp_wen = 0; exp_addr = 0; exp_data = 0; exp_run = 0; exp_err = 0;
  endtask

  task automatic make_stream(input int len, input bit good_cs);
    logic [7:0] x;
    logic [7:0] b;
    stream.delete();
    stream.push_back(len[15:8]);
    stream.push_back(len[7:0]);
    x = len[15:8] ^ len[7:0];
    if (len >= 1 && len <= MAXW) begin
      for (int i = 0; i < 2 * len; i++) begin
        b = 8'($urandom_range(255));
        stream.push_back(b);
        x = x ^ b;
      end
`ifdef CODE_LOADER_CHECKSUM_EN
      stream.push_back(good_cs ? x : (x ^ 8'h5A));
`endif
    end
  endtask

  // Translate the byte stream into the ordered list of slots the loader must step through.
  task automatic build_items();
    int len;
    logic [7:0] x;
    it_kind.delete(); it_byte.delete(); it_addr.delete(); it_data.delete();
    len = {stream[0], stream[1]};
    x = stream[0] ^ stream[1];
    for (int i = 0; i < 2; i++) begin
      it_kind.push_back(0); it_byte.push_back(int'(stream[i])); it_addr.push_back(0); it_data.push_back(0);
    end
    if (len == 0 || len > MAXW) begin
      exp_term = 1;
    end else begin
      for (int k = 0; k < len; k++) begin
        for (int j = 0; j < 2; j++) begin
          it_kind.push_back(0); it_byte.push_back(int'(stream[2 + 2 * k + j]));
          it_addr.push_back(0); it_data.push_back(0);
          x = x ^ stream[2 + 2 * k + j];
        end
        it_kind.push_back(1); it_byte.push_back(0); it_addr.push_back(k);
        it_data.push_back(int'({stream[2 + 2 * k], stream[3 + 2 * k]}));
      end
`ifdef CODE_LOADER_CHECKSUM_EN
      it_kind.push_back(0); it_byte.push_back(int'(stream[2 + 2 * len]));
      it_addr.push_back(0); it_data.push_back(0);
      exp_term = (stream[2 + 2 * len] == x) ? 0 : 1;
`else
      exp_term = 0;
`endif
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      load = 1'b0;
      in_valid = 1'($urandom_range(1));
      in_data = 8'($urandom_range(255));
      @(posedge clk); #1;
    end
  endtask

  // Run one load; gap is the percentage of byte-slot cycles with in_valid low.
  task automatic do_load(input int gap, input int abort_at);
    int idx;
    int n;
    bit v;
    wr_cyc.delete(); wr_addr.delete(); wr_data.delete();
    run_cyc = -1; err_cyc = -1;
    load = 1'b1;
    in_valid = 1'($urandom_range(1));
    in_data = 8'($urandom_range(255));
    load_cyc = cyc_n;
    @(posedge clk); #1;
    load = 1'b0;
    idx = 0; n = 0;
    while (idx < it_kind.size() && n < 10000) begin
      exp_busy = 1; exp_run = 0; exp_err = 0;
      if (it_kind[idx] == 0) begin
        exp_ready = 1; exp_wen = 0;
      end else begin
        exp_ready = 0; exp_wen = 1; exp_addr = it_addr[idx]; exp_data = it_data[idx];
      end
      if (idx == abort_at) begin
        rst = 1'b1; load = 1'b1; in_valid = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; load = 1'b0;
        exp_zero();
        return;
      end
      load = ($urandom_range(15) == 0);
      v = 1'b0;
      if (it_kind[idx] == 0) begin
        v = ($urandom_range(99) >= gap);
        in_valid = v;
        in_data = v ? 8'(it_byte[idx]) : 8'($urandom_range(255));
      end else begin
        in_valid = 1'($urandom_range(1));
        in_data = 8'($urandom_range(255));
      end
      @(posedge clk); #1;
      n++;
      if (it_kind[idx] == 1 || v) idx++;
    end
    if (n >= 10000) begin
      checks++; errors++;
      $display("FAIL timeout: load stuck at slot %0d of %0d", idx, it_kind.size());
    end
    load = 1'b0;
    exp_ready = 0; exp_busy = 0; exp_wen = 0;
    exp_run = (exp_term == 0) ? 1 : 0;
    exp_err = (exp_term == 1) ? 1 : 0;
    idle(3);
  endtask

  initial begin
    int len;
    rst = 1'b1; load = 1'b0; in_valid = 1'b0; in_data = 8'd0;
    exp_zero();
    @(posedge clk); #1;
    chk_en = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    idle(2);

    // Directed: two words, in_valid held high.
    stream = '{8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD};
`ifdef CODE_LOADER_CHECKSUM_EN
    stream.push_back(8'h42);
`endif
    build_items();
    do_load(0, -1);
    check("t1_nwrites", wr_cyc.size(), 2);
    if (wr_cyc.size() >= 2) begin
      check("t1_w0_cyc", wr_cyc[0], 5);
      check("t1_w0_addr", wr_addr[0], 0);
      check("t1_w0_data", wr_data[0], 16'h1234);
      check("t1_w1_cyc", wr_cyc[1], 8);
      check("t1_w1_addr", wr_addr[1], 1);
      check("t1_w1_data", wr_data[1], 16'hABCD);
    end
`ifdef CODE_LOADER_CHECKSUM_EN
    check("t1_run_cyc", run_cyc, 10);
`else
    check("t1_run_cyc", run_cyc, 9);
`endif

    // Bad headers: zero length and 513.
    stream = '{8'h00, 8'h00};
    build_items();
    do_load(0, -1);
    check("hdr0_err_cyc", err_cyc, 3);
    check("hdr0_nwrites", wr_cyc.size(), 0);
    check("hdr0_run", run_cyc, -1);
    stream = '{8'h02, 8'h01};
    build_items();
    do_load(0, -1);
    check("hdr513_err_cyc", err_cyc, 3);
    check("hdr513_nwrites", wr_cyc.size(), 0);
    check("hdr513_run", run_cyc, -1);

    // Full depth: 512 words with payload equal to address.
    stream.delete();
    stream.push_back(8'h02); stream.push_back(8'h00);
    begin
      logic [7:0] x;
      logic [15:0] a16;
      x = 8'h02;
      for (int a = 0; a < 512; a++) begin
        a16 = 16'(a);
        stream.push_back(a16[15:8]); stream.push_back(a16[7:0]);
        x = x ^ a16[15:8] ^ a16[7:0];
      end
`ifdef CODE_LOADER_CHECKSUM_EN
      stream.push_back(x);
`endif
    end
    build_items();
    do_load(0, -1);
    check("full_nwrites", wr_cyc.size(), 512);
    if (wr_cyc.size() == 512) begin
      check("full_last_addr", wr_addr[511], 16'h01FF);
      check("full_last_data", wr_data[511], 16'h01FF);
    end
`ifdef CODE_LOADER_CHECKSUM_EN
    check("full_run_cyc", run_cyc, 3 * 512 + 4);
`else
    check("full_run_cyc", run_cyc, 3 * 512 + 3);
`endif

    // Three words with random in_valid gaps.
    make_stream(3, 1'b1);
    build_items();
    do_load(40, -1);
    check("gap_nwrites", wr_cyc.size(), 3);

    // Reset during DATA_LO of word 1, then rst+load together in IDLE, then a fresh load.
    make_stream(3, 1'b1);
    build_items();
    do_load(0, 6);
    idle(2);
    rst = 1'b1; load = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; load = 1'b0;
    idle(2);
    make_stream(2, 1'b1);
    build_items();
    do_load(20, -1);
    check("restart_nwrites", wr_cyc.size(), 2);
    if (wr_cyc.size() >= 1) check("restart_addr0", wr_addr[0], 0);

`ifdef CODE_LOADER_CHECKSUM_EN
    stream = '{8'h00, 8'h01, 8'h12, 8'h34, 8'h27};
    build_items();
    do_load(0, -1);
    check("cs_good_run_cyc", run_cyc, 7);
    check("cs_good_err", err_cyc, -1);
    stream = '{8'h00, 8'h01, 8'h12, 8'h34, 8'h00};
    build_items();
    do_load(0, -1);
    check("cs_bad_err_cyc", err_cyc, 7);
    check("cs_bad_run", run_cyc, -1);
`endif

    // Randomized loads, including some oversize headers.
    for (int t = 0; t < 8; t++) begin
      if ($urandom_range(4) == 0) len = 513 + $urandom_range(200);
      else len = $urandom_range(1, 6);
      make_stream(len, ($urandom_range(3) != 0));
      build_items();
      do_load($urandom_range(50), -1);
    end

    chk_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
